// File: rtl/hist_eq_pkg.sv
// Shared definitions for the histogram-equalisation divider: FSM encoding,
// datapath width and the saturation level for the default configuration.
package hist_eq_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_LPOW   = 8;

  // Divider datapath width: enough for (cdf_in-cdf_min)*(2^LPOW-1) plus rounding.
  localparam int N   = DEF_DATA_W + DEF_LPOW + 1;
  localparam int SAT = (1 << DEF_LPOW) - 1;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_LOAD   = 2'd1;
  localparam state_t ST_DIVIDE = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  function automatic int div_width(input int data_w, input int lpow);
    return data_w + lpow + 1;
  endfunction

  function automatic int sat_level(input int lpow);
    return (1 << lpow) - 1;
  endfunction

endpackage

// File: rtl/restoring_div_core.sv
// Radix-2 restoring divider: one quotient bit per clock, MSB first, N steps.
// start loads the operands; done is high during the final step's cycle.
module restoring_div_core #(
  parameter int N = 41
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         done,
  output logic [N-1:0] quotient
);

  localparam int CW = $clog2(N);

  logic [N-1:0]  rem;
  logic [N-1:0]  quo;
  logic [N-1:0]  dvs;
  logic [CW-1:0] cnt;
  logic          run;

  logic [N:0]    trial;
  logic          ge;
  logic [N-1:0]  rem_sub;
  logic [N-1:0]  rem_next;
  logic [N-1:0]  quo_next;

  // The partial remainder is shifted left with the next dividend bit; the
  // subtraction result always fits in N bits because it is below the divisor.
  always_comb begin
    trial    = {rem, quo[N-1]};
    ge       = (trial >= {1'b0, dvs});
    rem_sub  = trial[N-1:0] - dvs;
    rem_next = ge ? rem_sub : trial[N-1:0];
    quo_next = {quo[N-2:0], ge};
  end

  assign done     = run && (cnt == '0);
  assign quotient = quo_next;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      rem <= '0;
      quo <= dividend;
      dvs <= divisor;
      cnt <= CW'(N - 1);
      run <= 1'b1;
    end else if (run) begin
      rem <= rem_next;
      quo <= quo_next;
      if (cnt == '0) run <= 1'b0;
      else           cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/equalize_divider.sv
// Histogram-equalisation level mapper: g = (cdf_in-cdf_min)*(2^LPOW-1)/(SIZE-cdf_min),
// with optional round-half-up, saturation and a divide-by-zero flag.
module equalize_divider
  import hist_eq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SIZE   = 1600,
  parameter int LPOW   = 8,
  parameter int ROUND  = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] cdf_min,
  input  logic [DATA_W-1:0] cdf_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LPOW-1:0]   g_out,
  output logic              div_by_zero,
  output logic              busy,
  output state_t            state_dbg
);

  localparam int           NW     = div_width(DATA_W, LPOW);
  localparam logic [NW-1:0] SAT_N  = NW'(sat_level(LPOW));
  localparam logic [NW-1:0] SIZE_N = NW'(SIZE);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and outputs hold while stalled.

  state_t            state;
  logic [DATA_W-1:0] min_q;
  logic [DATA_W-1:0] in_q;

  logic [DATA_W-1:0] diff_dw;
  logic [NW-1:0]     diff;
  logic [NW-1:0]     min_ext;
  logic [NW-1:0]     num;
  logic [NW-1:0]     den;
  logic [NW-1:0]     dividend;
  logic              den_zero;

  logic              div_start;
  logic              div_done;
  logic [NW-1:0]     quotient;
  logic [LPOW-1:0]   g_next;

  always_comb begin
    diff_dw  = in_q - min_q;
    diff     = {{(NW-DATA_W){1'b0}}, diff_dw};
    min_ext  = {{(NW-DATA_W){1'b0}}, min_q};
    num      = ((in_q == '0) || (in_q < min_q)) ? '0 : ((diff << LPOW) - diff);
    den      = (min_ext < SIZE_N) ? (SIZE_N - min_ext) : '0;
    den_zero = (den == '0);
    dividend = ((ROUND != 0) && !den_zero) ? (num + (den >> 1)) : num;
    g_next   = (quotient > SAT_N) ? SAT_N[LPOW-1:0] : quotient[LPOW-1:0];
  end

  assign div_start = (state == ST_LOAD) && !den_zero;

  restoring_div_core #(
    .N(NW)
  ) u_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (den),
    .done     (div_done),
    .quotient (quotient)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      min_q       <= '0;
      in_q        <= '0;
      g_out       <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            min_q <= cdf_min;
            in_q  <= cdf_in;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (den_zero) begin
            g_out       <= SAT_N[LPOW-1:0];
            div_by_zero <= 1'b1;
            state       <= ST_DONE;
          end else begin
            state <= ST_DIVIDE;
          end
        end
        ST_DIVIDE: begin
          if (div_done) begin
            g_out       <= g_next;
            div_by_zero <= 1'b0;
            state       <= ST_DONE;
          end
        end
        default: begin
          if (out_ready) state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_equalize_divider.sv
// Bench for equalize_divider: a truncating and a rounding instance share the
// same stimulus; a negedge monitor checks results against an expected queue.
module tb_equalize_divider;
  import hist_eq_pkg::*;

  localparam int SIZE   = 1600;
  localparam int LAT    = N + 2;
  localparam int PERIOD = N + 3;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] cdf_min;
  logic [31:0] cdf_in;

  logic        in_ready,  out_valid,  div_by_zero,  busy;
  logic        in_ready_r, out_valid_r, div_by_zero_r, busy_r;
  logic [7:0]  g_out, g_out_r;
  state_t      state_dbg, state_dbg_r;

  equalize_divider #(.DATA_W(32), .SIZE(SIZE), .LPOW(8), .ROUND(0)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .cdf_min(cdf_min), .cdf_in(cdf_in), .out_valid(out_valid), .out_ready(out_ready),
    .g_out(g_out), .div_by_zero(div_by_zero), .busy(busy), .state_dbg(state_dbg)
  );

  equalize_divider #(.DATA_W(32), .SIZE(SIZE), .LPOW(8), .ROUND(1)) u_dut_rnd (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_r),
    .cdf_min(cdf_min), .cdf_in(cdf_in), .out_valid(out_valid_r), .out_ready(out_ready),
    .g_out(g_out_r), .div_by_zero(div_by_zero_r), .busy(busy_r), .state_dbg(state_dbg_r)
  );

  typedef struct packed {
    logic [7:0] g0;
    logic [7:0] g1;
    logic       dbz;
    int         acc;
    int         lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: integer arithmetic straight from the equalisation formula.
  function automatic logic [7:0] ref_g(input longint mn, input longint v, input int rnd);
    longint num, den, q;
    if (mn >= SIZE) return 8'd255;
    num = (v == 0 || v < mn) ? 0 : (v - mn) * 255;
    den = SIZE - mn;
    q   = (num + (rnd != 0 ? den / 2 : 0)) / den;
    return (q > 255) ? 8'd255 : q[7:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input int budget);
    int n = 0;
    while (!in_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("ready_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || !in_ready) check("idle_timeout", 0, 1);
  endtask

  task automatic send(input logic [31:0] mn, input logic [31:0] v,
                      input logic [7:0] g0, input logic [7:0] g1, input logic dbz);
    exp_t e;
    wait_ready(200);
    cdf_min  = mn;
    cdf_in   = v;
    in_valid = 1'b1;
    e.g0 = g0; e.g1 = g1; e.dbz = dbz; e.acc = cyc; e.lat = dbz ? 2 : LAT;
    exp_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  // Latency is counted in rising edges, including the accepting edge.
  logic       seen = 1'b0;
  int         first_cyc;
  logic [7:0] hold_g0, hold_g1;
  logic       hold_dbz;

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!reset_n) begin
      seen = 1'b0;
    end else begin
      check("twin_ctrl", {in_ready_r, busy_r, state_dbg_r, out_valid_r},
                         {in_ready, busy, state_dbg, out_valid});
      if (out_valid) begin
        if (!seen) begin
          seen      = 1'b1;
          first_cyc = cyc;
          hold_g0   = g_out;
          hold_g1   = g_out_r;
          hold_dbz  = div_by_zero;
        end else begin
          check("stall_g_out", g_out, hold_g0);
          check("stall_g_out_rnd", g_out_r, hold_g1);
          check("stall_dbz", div_by_zero, hold_dbz);
        end
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("g_out_trunc", g_out, e.g0);
            check("g_out_round", g_out_r, e.g1);
            check("div_by_zero", div_by_zero, e.dbz);
            check("div_by_zero_rnd", div_by_zero_r, e.dbz);
            check("latency", first_cyc - e.acc, e.lat);
          end
          seen = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int prev_acc;
    logic [31:0] v;
    exp_t e;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cdf_min   = '0;
    cdf_in    = '0;
    repeat (3) @(negedge clk);
    check("rst_state", state_dbg, ST_IDLE);
    check("rst_out_valid", out_valid, 0);
    check("rst_g_out", g_out, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed vectors, expected values worked by hand.
    send(32'd100,  32'd850,  8'd127, 8'd128, 1'b0);  // 191250/1500 = 127.5
    send(32'd100,  32'd1600, 8'd255, 8'd255, 1'b0);
    send(32'd100,  32'd0,    8'd0,   8'd0,   1'b0);
    send(32'd100,  32'd50,   8'd0,   8'd0,   1'b0);  // below cdf_min
    send(32'd100,  32'd100,  8'd0,   8'd0,   1'b0);
    send(32'd100,  32'd103,  8'd0,   8'd1,   1'b0);  // 765/1500 = 0.51
    send(32'd100,  32'd106,  8'd1,   8'd1,   1'b0);  // 1530/1500 = 1.02
    send(32'd0,    32'd800,  8'd127, 8'd128, 1'b0);  // 204000/1600 = 127.5
    send(32'd0,    32'd1600, 8'd255, 8'd255, 1'b0);  // 255.0 exactly
    send(32'd100,  32'hFFFF_FFFF, 8'd255, 8'd255, 1'b0);  // saturates
    send(32'd1600, 32'd1600, 8'd255, 8'd255, 1'b1);  // den == 0
    send(32'd2000, 32'd5,    8'd255, 8'd255, 1'b1);  // cdf_min > SIZE
    wait_idle(300);

    // Consumer stall for 5 cycles in DONE, with in_valid noise while busy.
    out_ready = 1'b0;
    send(32'd100, 32'd850, 8'd127, 8'd128, 1'b0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      cdf_min  = 32'd7;
      cdf_in   = 32'd999;
      check("in_ready_divide", in_ready, 0);
      n++;
    end
    if (!out_valid) check("done_timeout", 0, 1);
    repeat (5) begin
      @(negedge clk);
      in_valid = ~in_valid;
      check("in_ready_done", in_ready, 0);
      check("out_valid_held", out_valid, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle(50);

    // Reset in DIVIDE cycle 20 aborts the operation without a result.
    wait_ready(50);
    cdf_min  = 32'd100;
    cdf_in   = 32'd850;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    repeat (19) @(negedge clk);
    check("abort_in_divide", state_dbg, ST_DIVIDE);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_state", state_dbg, ST_IDLE);
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    reset_n = 1'b1;
    @(negedge clk);
    send(32'd100, 32'd850, 8'd127, 8'd128, 1'b0);
    wait_idle(100);

    // Back-to-back stream with in_valid and out_ready held high.
    cdf_min  = 32'd200;
    in_valid = 1'b1;
    prev_acc = 0;
    for (int i = 0; i < 256; i++) begin
      wait_ready(100);
      v       = $urandom_range(0, 2000);
      cdf_in  = v;
      e.g0 = ref_g(200, longint'(v), 0);
      e.g1 = ref_g(200, longint'(v), 1);
      e.dbz = 1'b0; e.acc = cyc; e.lat = LAT;
      exp_q.push_back(e);
      if (i > 0) check("accept_period", cyc - prev_acc, PERIOD);
      prev_acc = cyc;
      @(negedge clk);
      if (i == 255) in_valid = 1'b0;
    end
    wait_idle(200);

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/equalize_divider.md
EQUALIZE_DIVIDER -- requirements
Module: equalize_divider

Interface
REQ-001 Parameter DATA_W, default 32, width of cdf_min/cdf_in.
REQ-002 Parameter SIZE, default 1600, pixel count per frame; SHALL fit in DATA_W bits.
REQ-003 Parameter LPOW, default 8, log2 of grey levels; output range 0..2^LPOW-1.
REQ-004 Parameter ROUND, default 0, 0 = truncate quotient, 1 = round half up.
REQ-005 clk  input  1  rising-edge clock; the block's only clock.
REQ-006 reset_n  input  1  synchronous, active-low reset.
REQ-007 in_valid  input  1  cdf_min/cdf_in valid this cycle.
REQ-008 in_ready  output  1  block can accept a new operand pair.
REQ-009 cdf_min  input  DATA_W  minimum non-zero CDF value of the frame.
REQ-010 cdf_in  input  DATA_W  CDF value of the current grey level.
REQ-011 out_valid  output  1  g_out/div_by_zero valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 g_out  output  LPOW  equalised grey level.
REQ-014 div_by_zero  output  1  denominator was zero for this result.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 Let N = DATA_W+LPOW+1; all numerator, denominator and remainder datapaths SHALL be N bits, unsigned.
REQ-017 Numerator num = (cdf_in-cdf_min)*(2^LPOW-1), computed as shift-left-by-LPOW minus operand; num SHALL be 0 when cdf_in==0 or cdf_in<cdf_min.
REQ-018 Denominator den = SIZE-cdf_min when cdf_min<SIZE, else 0.
REQ-019 When ROUND=1 and den!=0, the divided value SHALL be num+(den>>1); otherwise num.
REQ-020 FSM states: IDLE, LOAD, DIVIDE, DONE.
REQ-021 IDLE: in_ready=1; in_valid&in_ready SHALL register both inputs and move to LOAD.
REQ-022 LOAD: one cycle; compute num/den per REQ-017..019, clear remainder, load the iteration counter with N-1, move to DIVIDE.
REQ-023 DIVIDE: restoring radix-2, one quotient bit per cycle MSB first, exactly N cycles, then DONE.
REQ-024 If den==0 in LOAD, the block SHALL skip DIVIDE, go directly to DONE with g_out=2^LPOW-1 and div_by_zero=1.
REQ-025 Latency: out_valid SHALL rise exactly N+2 rising edges after the accepting edge (2 edges when den==0).
REQ-026 Quotient values above 2^LPOW-1 SHALL saturate to 2^LPOW-1.
REQ-027 DONE: out_valid=1 and g_out/div_by_zero held stable until out_valid&out_ready; then go to IDLE.
REQ-028 in_ready SHALL be 0 in LOAD, DIVIDE and DONE; in_valid in those states is ignored, and no operands are lost because no handshake occurs.
REQ-029 Throughput: one result per N+3 cycles with out_ready tied high.

Reset
REQ-030 While reset_n==0 at a rising edge: state=IDLE, out_valid=0, g_out=0, div_by_zero=0, busy=0, in_ready=1 on the following cycle.
REQ-031 Reset asserted during LOAD/DIVIDE/DONE SHALL abort the operation with no result emitted.

Structure
REQ-032 State enum, N and the saturation constant 2^LPOW-1 SHALL live in shared package hist_eq_pkg.
REQ-033 The iterative divide datapath SHALL be sub-module restoring_div_core (width parameter N, start/done handshake); equalize_divider holds the FSM, operand registers, rounding and saturation.

Verification (DATA_W=32, SIZE=1600, LPOW=8; N=41)
REQ-034 ROUND=0, cdf_min=100, cdf_in=850 -> g_out=127 (191250/1500), div_by_zero=0, out_valid 43 edges after accept; ROUND=1 -> g_out=128.
REQ-035 cdf_min=100, cdf_in=1600 -> g_out=255; cdf_in=0 -> g_out=0; cdf_in=50 (<cdf_min) -> g_out=0.
REQ-036 cdf_min=1600, cdf_in=1600 -> g_out=255, div_by_zero=1, out_valid 2 edges after accept.
REQ-037 out_ready held low 5 cycles in DONE -> out_valid, g_out and div_by_zero stable; in_valid pulses during DIVIDE and DONE are not accepted (in_ready=0).
REQ-038 reset_n pulled low at DIVIDE cycle 20 -> next cycle IDLE, out_valid=0, in_ready=1; a new operand pair is then processed correctly.
REQ-039 Back-to-back stream with in_valid and out_ready tied high over 256 random cdf_in values -> one accept per 44 cycles, every g_out matches the reference model.
